// File: rtl/mem_apb4_rr_bridge.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_apb4_rr_bridge - round-robin multi-channel APB4 master with PREADY watchdog
// Rev 1.0
// -----------------------------------------------------------------------------
module mem_apb4_rr_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                              PCLK,
    input  logic                              PRESET,
    output logic [ADDR_WIDTH-1:0]             PADDR,
    output logic                              PSEL,
    output logic                              PENABLE,
    output logic                              PWRITE,
    output logic [DATA_WIDTH-1:0]             PWDATA,
    output logic [DATA_WIDTH/8-1:0]           PSTRB,
    output logic [2:0]                        PPROT,
    input  logic                              PREADY,
    input  logic [DATA_WIDTH-1:0]             PRDATA,
    input  logic                              PSLVERR,
    input  logic [NUM_CH-1:0]                 req,
    input  logic [NUM_CH-1:0]                 req_write,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      req_wdata,
    input  logic [NUM_CH*(DATA_WIDTH/8)-1:0]  req_strb,
    input  logic [NUM_CH*3-1:0]               req_prot,
    output logic [NUM_CH-1:0]                 gnt,
    output logic [NUM_CH-1:0]                 done,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_err,
    output logic                              rsp_timeout
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN  = (TIMEOUT > 0);

    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [PTR_W-1:0]       ptr_q;
    logic [WD_W-1:0]        wd_q;
    logic [NUM_CH-1:0]      cur_oh_q;
    logic [ADDR_WIDTH-1:0]  paddr_q;
    logic                   pwrite_q;
    logic [DATA_WIDTH-1:0]  pwdata_q;
    logic [STRB_W-1:0]      pstrb_q;
    logic [2:0]             pprot_q;
    logic [NUM_CH-1:0]      gnt_q, done_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   err_q, to_q;

    logic                   w_any_req, w_xfer_done, w_wd_expire, w_arb_en;
    logic                   w_hi_found, w_lo_found;
    logic [PTR_W-1:0]       w_hi_idx, w_lo_idx, w_win_idx, w_ptr_nxt;
    logic [NUM_CH-1:0]      w_win_oh;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic                   w_write;
    logic [DATA_WIDTH-1:0]  w_wdata;
    logic [STRB_W-1:0]      w_strb;
    logic [2:0]             w_prot;

    assign w_any_req   = |req;
    assign w_xfer_done = (state_q == S_ACCESS) && PREADY;
    assign w_wd_expire = WD_EN && (state_q == S_ACCESS) && !PREADY && (wd_q == WD_LIMIT);
    assign w_arb_en    = w_any_req && ((state_q == S_IDLE) || w_xfer_done);

    // Rotating priority: first request at or above ptr, else wrap to the lowest one.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && !w_hi_found && (PTR_W'(i) >= ptr_q)) begin
                w_hi_found = 1'b1;
                w_hi_idx   = PTR_W'(i);
            end
            if (req[i] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = PTR_W'(i);
            end
        end
        w_win_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        w_ptr_nxt = (w_win_idx == LAST_CH) ? '0 : w_win_idx + 1'b1;
    end

    always_comb begin
        w_win_oh = '0;
        w_addr   = '0;
        w_write  = 1'b0;
        w_wdata  = '0;
        w_strb   = '0;
        w_prot   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (PTR_W'(i) == w_win_idx) begin
                w_win_oh[i] = 1'b1;
                w_addr      = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_write     = req_write[i];
                w_wdata     = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_strb      = req_strb[i*STRB_W +: STRB_W];
                w_prot      = req_prot[i*3 +: 3];
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (w_any_req) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (PREADY) begin
                    state_d = w_any_req ? S_SETUP : S_IDLE;
                end else if (w_wd_expire) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Decoded straight from the state register so reset drops them without waiting for a clock.
    always_comb begin
        PSEL    = (state_q != S_IDLE);
        PENABLE = (state_q == S_ACCESS);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ptr_q    <= '0;
            wd_q     <= '0;
            cur_oh_q <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            if (w_arb_en) begin
                paddr_q  <= w_addr;
                pwrite_q <= w_write;
                pwdata_q <= w_wdata;
                pstrb_q  <= w_write ? w_strb : '0;
                pprot_q  <= w_prot;
                gnt_q    <= w_win_oh;
                cur_oh_q <= w_win_oh;
                ptr_q    <= w_ptr_nxt;
            end
            if (w_xfer_done) begin
                done_q  <= cur_oh_q;
                err_q   <= PSLVERR;
                rdata_q <= pwrite_q ? '0 : PRDATA;
            end else if (w_wd_expire) begin
                done_q <= cur_oh_q;
                err_q  <= 1'b1;
                to_q   <= 1'b1;
            end
            if (state_q == S_SETUP) begin
                wd_q <= '0;
            end else if (WD_EN && (state_q == S_ACCESS) && !PREADY && !w_wd_expire) begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;
    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_apb4_rr_bridge.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mem_apb4_rr_bridge - directed bench with a transaction-level reference model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_mem_apb4_rr_bridge;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TO  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   PADDR;
    logic            PSEL, PENABLE, PWRITE;
    logic [DW-1:0]   PWDATA;
    logic [DW/8-1:0] PSTRB;
    logic [2:0]      PPROT;
    logic            PREADY;
    logic [DW-1:0]   PRDATA;
    logic            PSLVERR;
    logic [NCH-1:0]  req, req_write;
    logic [NCH*AW-1:0]     req_addr;
    logic [NCH*DW-1:0]     req_wdata;
    logic [NCH*(DW/8)-1:0] req_strb;
    logic [NCH*3-1:0]      req_prot;
    logic [NCH-1:0]  gnt, done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err, rsp_timeout;

    mem_apb4_rr_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .TIMEOUT(TO)
    ) dut (
        .PCLK(clk), .PRESET(rst),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_strb(req_strb), .req_prot(req_prot),
        .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: a transfer is "cycle 1 = SETUP, then ACCESS cycles",
    // finishing after min(waits, TIMEOUT)+1 ACCESS cycles.
    bit  m_active, m_to, m_write;
    int  m_ptr, m_ch, m_cyc, m_fin;
    logic           e_psel, e_penable, e_pwrite, e_err, e_to;
    logic [NCH-1:0] e_gnt, e_done;
    logic [DW-1:0]  e_rdata, e_pwdata;
    logic [AW-1:0]  e_paddr;
    logic [3:0]     e_pstrb;
    logic [2:0]     e_pprot;

    int   s_waits, s_cnt, n_access;
    logic s_err;
    logic [DW-1:0] s_rdata;

    int rq_cnt[NCH];
    int g_ch[$];
    int g_cyc[$];
    int exp_fair[6] = '{0, 1, 2, 3, 0, 1};
    int dcount;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_to = 0; m_write = 0;
        m_ptr = 0; m_ch = 0; m_cyc = 0; m_fin = 0;
        e_psel = 0; e_penable = 0; e_pwrite = 0; e_err = 0; e_to = 0;
        e_gnt = '0; e_done = '0; e_rdata = '0; e_pwdata = '0;
        e_paddr = '0; e_pstrb = '0; e_pprot = '0;
    endtask

    task automatic model_step();
        bit arb_ok;
        bit found;
        int w;
        e_gnt = '0; e_done = '0; e_err = 0; e_to = 0; e_rdata = '0;
        arb_ok = 1;
        if (m_active) begin
            arb_ok = 0;
            if (m_cyc == m_fin + 1) begin
                e_done[m_ch] = 1'b1;
                e_to    = m_to;
                e_err   = m_to ? 1'b1 : s_err;
                e_rdata = (m_to || m_write) ? '0 : s_rdata;
                m_active = 0;
                arb_ok   = !m_to;
            end else begin
                m_cyc++;
            end
        end
        if (arb_ok && !m_active && (req != '0)) begin
            found = 0; w = 0;
            for (int i = 0; i < NCH; i++) begin
                if (!found && req[(m_ptr + i) % NCH]) begin
                    found = 1;
                    w = (m_ptr + i) % NCH;
                end
            end
            m_ptr    = (w + 1) % NCH;
            m_ch     = w;
            m_active = 1;
            m_cyc    = 1;
            m_fin    = ((s_waits < TO) ? s_waits : TO) + 1;
            m_to     = (s_waits > TO);
            m_write  = req_write[w];
            e_gnt[w] = 1'b1;
            e_paddr  = req_addr[w*AW +: AW];
            e_pwrite = req_write[w];
            e_pwdata = req_wdata[w*DW +: DW];
            e_pstrb  = req_write[w] ? req_strb[w*4 +: 4] : 4'h0;
            e_pprot  = req_prot[w*3 +: 3];
        end
        e_psel    = m_active;
        e_penable = m_active && (m_cyc >= 2);
    endtask

    task automatic compare_cycle();
        chk("psel", PSEL, e_psel);
        chk("penable", PENABLE, e_penable);
        chk("gnt", gnt, e_gnt);
        chk("done", done, e_done);
        chk("rsp_err", rsp_err, e_err);
        chk("rsp_timeout", rsp_timeout, e_to);
        if (e_done != '0) chk("rsp_rdata", rsp_rdata, e_rdata);
        if (e_psel) begin
            chk("paddr", PADDR, e_paddr);
            chk("pwrite", PWRITE, e_pwrite);
            chk("pwdata", PWDATA, e_pwdata);
            chk("pstrb", PSTRB, e_pstrb);
            chk("pprot", PPROT, e_pprot);
        end
    endtask

    task automatic slave_step();
        if (PSEL && PENABLE) begin
            n_access++;
            PREADY  = (s_cnt >= s_waits);
            PSLVERR = PREADY ? s_err : 1'b0;
            PRDATA  = s_rdata;
            s_cnt++;
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = '0;
            s_cnt   = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        slave_step();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        for (int k = 0; k < NCH; k++) begin
            if (gnt[k]) begin
                g_ch.push_back(k);
                g_cyc.push_back(cyc);
                if (rq_cnt[k] > 0) rq_cnt[k]--;
                if (rq_cnt[k] == 0) req[k] = 1'b0;
            end
        end
    endtask

    task automatic start_req(input int k, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [3:0] s,
                             input logic [2:0] p, input int n);
        req_write[k]          = wr;
        req_addr[k*AW +: AW]  = a;
        req_wdata[k*DW +: DW] = d;
        req_strb[k*4 +: 4]    = s;
        req_prot[k*3 +: 3]    = p;
        rq_cnt[k]             = n;
        req[k]                = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((m_active || (req != '0)) && t < 100) begin
            tick();
            t++;
        end
        chk("drain_budget", (t < 100), 1'b1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        s_waits = 0; s_cnt = 0; n_access = 0; s_err = 1'b0; s_rdata = '0;
        for (int k = 0; k < NCH; k++) rq_cnt[k] = 0;
        model_reset();

        #7;
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_gnt", gnt, 4'h0);
        chk("rst_done", done, 4'h0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pstrb", PSTRB, 4'h0);
        chk("rst_rsp", {rsp_err, rsp_timeout, rsp_rdata}, 34'h0);
        rst = 1'b0;
        tick(); tick();

        // Fairness: all four requesting, grants must rotate 0,1,2,3,0,1 every 2 cycles
        s_rdata = 32'hCAFE0000;
        start_req(0, 1'b0, 32'h1000, 32'h0,        4'hF, 3'b000, 2);
        start_req(1, 1'b1, 32'h1004, 32'h11111111, 4'hF, 3'b001, 2);
        start_req(2, 1'b0, 32'h1008, 32'h0,        4'h3, 3'b000, 1);
        start_req(3, 1'b1, 32'h100C, 32'h33333333, 4'hC, 3'b100, 1);
        g_ch.delete(); g_cyc.delete();
        drain();
        chk("fair_count", g_ch.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < g_ch.size()) chk("fair_order", g_ch[i], exp_fair[i]);
            if (i > 0 && i < g_cyc.size()) chk("fair_gap", g_cyc[i] - g_cyc[i-1], 2);
        end

        // Pointer rotation: ptr is 2 here, req=0011 wraps to ch0 then ch1
        g_ch.delete(); g_cyc.delete();
        start_req(0, 1'b0, 32'h2000, 32'h0, 4'h0, 3'b000, 1);
        start_req(1, 1'b0, 32'h2004, 32'h0, 4'h0, 3'b000, 1);
        drain();
        chk("rot_count", g_ch.size(), 2);
        if (g_ch.size() > 0) chk("rot_first", g_ch[0], 0);
        if (g_ch.size() > 1) chk("rot_second", g_ch[1], 1);

        // Single read on ch0 with zero-wait slave
        s_rdata = 32'hDEADBEEF;
        start_req(0, 1'b0, 32'h100, 32'h55AA55AA, 4'hF, 3'b000, 1);
        tick();
        chk("rd_gnt", gnt, 4'b0001);
        chk("rd_setup_psel", PSEL, 1'b1);
        chk("rd_setup_penable", PENABLE, 1'b0);
        chk("rd_pstrb", PSTRB, 4'h0);
        chk("rd_paddr", PADDR, 32'h100);
        tick();
        chk("rd_access_penable", PENABLE, 1'b1);
        tick();
        chk("rd_done", done, 4'b0001);
        chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd_err", rsp_err, 1'b0);
        drain();

        // Write on ch3 with 2 wait states and PSLVERR
        s_waits = 2; s_err = 1'b1;
        start_req(3, 1'b1, 32'h300, 32'hA5A5A5A5, 4'b0101, 3'b010, 1);
        tick();
        chk("wr_gnt", gnt, 4'b1000);
        chk("wr_pstrb", PSTRB, 4'b0101);
        chk("wr_pprot", PPROT, 3'b010);
        chk("wr_pwdata", PWDATA, 32'hA5A5A5A5);
        tick(); tick(); tick();
        chk("wr_not_done_yet", done, 4'h0);
        tick();
        chk("wr_done", done, 4'b1000);
        chk("wr_err", rsp_err, 1'b1);
        chk("wr_timeout", rsp_timeout, 1'b0);
        chk("wr_rdata", rsp_rdata, 32'h0);
        s_waits = 0; s_err = 1'b0;
        drain();

        // Timeout on ch2; ch0 queued behind it must start only after an IDLE cycle
        s_waits = 1000; n_access = 0;
        start_req(2, 1'b0, 32'h200, 32'h0, 4'hF, 3'b001, 1);
        tick();
        chk("to_gnt", gnt, 4'b0100);
        start_req(0, 1'b0, 32'h104, 32'h0, 4'hF, 3'b000, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("to_still_busy", PSEL, 1'b1);
        chk("to_no_done_early", done, 4'h0);
        tick();
        chk("to_done", done, 4'b0100);
        chk("to_err", rsp_err, 1'b1);
        chk("to_flag", rsp_timeout, 1'b1);
        chk("to_rdata", rsp_rdata, 32'h0);
        chk("to_psel", PSEL, 1'b0);
        chk("to_access_cycles", n_access, 5);
        s_waits = 0; s_rdata = 32'h12345678;
        tick();
        chk("after_to_gnt", gnt, 4'b0001);
        tick(); tick();
        chk("after_to_done", done, 4'b0001);
        chk("after_to_flag", rsp_timeout, 1'b0);
        chk("after_to_rdata", rsp_rdata, 32'h12345678);
        drain();

        // Async reset mid-ACCESS on ch1 (ptr would be 2 without the reset)
        s_waits = 3;
        start_req(1, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000, 1);
        tick();
        chk("ar_gnt", gnt, 4'b0010);
        tick(); tick();
        #1 rst = 1'b1;
        #1;
        chk("ar_psel", PSEL, 1'b0);
        chk("ar_penable", PENABLE, 1'b0);
        chk("ar_gnt0", gnt, 4'h0);
        chk("ar_done0", done, 4'h0);
        model_reset();
        req = '0;
        for (int k = 0; k < NCH; k++) rq_cnt[k] = 0;
        PREADY = 1'b0; PSLVERR = 1'b0; s_cnt = 0; s_waits = 0;
        #4 rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done != '0) dcount++;
        end
        chk("ar_no_done", dcount, 0);
        g_ch.delete(); g_cyc.delete();
        start_req(0, 1'b0, 32'h500, 32'h0, 4'h0, 3'b000, 1);
        start_req(2, 1'b0, 32'h508, 32'h0, 4'h0, 3'b000, 1);
        drain();
        chk("ar_count", g_ch.size(), 2);
        if (g_ch.size() > 0) chk("ar_ptr_first", g_ch[0], 0);
        if (g_ch.size() > 1) chk("ar_ptr_second", g_ch[1], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_apb4_rr_bridge.md
# mem_apb4_rr_bridge

Multi-channel APB4 master bridge for the memory subsystem. Up to NUM_CH independent requesters are arbitrated with a rotating-pointer round-robin, and one APB4 transfer at a time runs on a shared bus. It adds PSTRB/PPROT, a per-transfer PREADY timeout watchdog, and per-channel grant/done handshakes. It sits between the memory-side request ports and the APB peripheral fabric.

## Interface
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be a multiple of 8
- ADDR_WIDTH, 32, PADDR width
- NUM_CH, 4, number of requester channels; must be 1 or more
- TIMEOUT, 255, maximum wait cycles in ACCESS with PREADY low; 0 disables the watchdog
- PCLK  in  1  clock
- PRESET  in  1  reset; one clock; reset is asynchronous and active-high
- PADDR  out  ADDR_WIDTH  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  DATA_WIDTH/8  APB write strobes
- PPROT  out  3  APB protection
- PREADY  in  1  slave ready
- PRDATA  in  DATA_WIDTH  slave read data
- PSLVERR  in  1  slave error
- req  in  NUM_CH  per-channel request
- req_write  in  NUM_CH  per-channel direction; 1 = write
- req_addr  in  NUM_CH*ADDR_WIDTH  packed addresses; channel k is in slice k
- req_wdata  in  NUM_CH*DATA_WIDTH  packed write data
- req_strb  in  NUM_CH*DATA_WIDTH/8  packed strobes
- req_prot  in  NUM_CH*3  packed PPROT values
- gnt  out  NUM_CH  one-hot, one-cycle pulse: request captured
- done  out  NUM_CH  one-hot, one-cycle pulse: transfer finished
- rsp_rdata  out  DATA_WIDTH  read data, valid while done is high
- rsp_err  out  1  error, valid while done is high
- rsp_timeout  out  1  timeout flag, valid while done is high

## Operation
- States and transitions:
  - IDLE to SETUP when any req is high at an edge.
  - SETUP to ACCESS unconditionally.
  - ACCESS with PREADY high to SETUP if any req is high, otherwise to IDLE.
  - ACCESS with the watchdog expired to IDLE.
- Arbitration happens only at the IDLE-to-SETUP and ACCESS-completion edges.
  - Winner: the first set bit of req, searched upward from pointer ptr, modulo NUM_CH.
  - After granting channel k, ptr becomes (k+1) mod NUM_CH.
  - ptr is 0 at reset. With NUM_CH=1, ptr is always 0.
- Capture at the arbitration edge:
  - The winner's address, direction, data, strobe and prot are registered onto PADDR, PWRITE, PWDATA, PSTRB and PPROT.
  - These stay stable through SETUP and ACCESS.
- On reads, PSTRB is forced to 0. PWDATA is don't-care but is still registered.
- PSEL is 1 in SETUP and ACCESS, 0 in IDLE. PENABLE is 1 only in ACCESS.
- Requester rules:
  - Hold req[k] and its fields stable until gnt[k] is seen.
  - Keeping req high after gnt means a new request; the fields must be updated at the edge where gnt is seen.
- Completion, when PREADY is high in ACCESS:
  - done[k] pulses for the channel that was granted.
  - rsp_err = PSLVERR and rsp_timeout = 0.
  - rsp_rdata = PRDATA for reads, 0 for writes.
- Watchdog: a counter of width clog2(TIMEOUT+1) is cleared on entry to ACCESS and increments each ACCESS cycle with PREADY low.
- Watchdog expiry: if PREADY is still low when the counter equals TIMEOUT:
  - The transfer is abandoned, PSEL and PENABLE drop, and the bridge goes to IDLE. No back-to-back transfer follows.
  - done[k] pulses with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- PREADY and expiry in the same cycle: PREADY wins and the transfer completes normally.

## Timing
- Reset values: every output is 0, state is IDLE, ptr is 0, the watchdog counter is 0.
- PRESET asserted mid-transfer: the bridge goes immediately to the reset values. PSEL and PENABLE drop asynchronously. No done is issued for the aborted transfer.
- Latency from req sampled at edge E0:
  - SETUP runs in the cycle after E0, with gnt[k]=1 during SETUP.
  - ACCESS runs from edge E1.
  - With a zero-wait slave, completion is at E2 and done[k] is high in the cycle after E2.
- Each wait state adds one cycle.
- Back-to-back transfers: the new SETUP follows the completion edge directly, with PSEL staying 1 and PENABLE dropping to 0. A zero-wait slave sustains one transfer every 2 cycles.
- gnt, done, rsp_err and rsp_timeout are registered outputs and are never high for more than one cycle per transfer.
- done and gnt may be high in the same cycle for different channels, or for the same channel during back-to-back.

## Test plan
- Single read, NUM_CH=4: ch0 reads 0x100, zero-wait slave, PRDATA=0xDEADBEEF.
  - Required: SETUP then ACCESS with PSTRB=0.
  - Required: done=4'b0001 and rsp_rdata=0xDEADBEEF, 3 cycles after req is sampled.
- Fairness: all four channels assert req continuously, zero-wait slave.
  - Required: grant order 0,1,2,3,0,1, one transfer every 2 cycles, PSEL never low.
- Pointer rotation: ptr=2 (after a grant to ch1), req=4'b0011.
  - Required: ch0 wins, then ptr=1, and ch1 wins next.
- Write with error: ch3 writes 0xA5A5A5A5, strb 4'b0101, prot 3'b010, slave applies 2 wait states then PREADY with PSLVERR.
  - Required: PSTRB=0101 and PPROT=010 held throughout.
  - Required: done=4'b1000, rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout, TIMEOUT=4: slave holds PREADY low indefinitely.
  - Required: the bridge exits ACCESS after 5 ACCESS cycles, with done pulse, rsp_err=1, rsp_timeout=1, PSEL=0.
  - Required: the next transfer proceeds normally.
- Async reset: assert PRESET for a half cycle during ACCESS.
  - Required: PSEL, PENABLE, gnt and done go to 0 immediately, no done is issued, ptr returns to 0.
